// File: rtl/mem_bridge.sv
// mem_bridge
// Bridges a level-held CPU request (mem_read/mem_write, held until mem_resp)
// onto a valid/ready request + ack completion physical memory port.
// One access is in flight at a time. A WAIT phase longer than TIMEOUT cycles
// aborts the access with 32'hDEADBEEF as read data and raises the sticky err.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_read, mem_write            CPU request levels
//   mem_byte_enable[3:0]           CPU write byte mask
//   mem_address[31:0]              CPU byte address
//   mem_wdata[31:0]                CPU write data
//   mem_resp, mem_rdata[31:0]      one-cycle completion pulse and read data
//   pmem_valid, pmem_ready         request handshake to physical memory
//   pmem_we, pmem_addr, pmem_wdata, pmem_wmask   request fields
//   pmem_ack, pmem_rdata           completion pulse and read data from memory
//   err                            sticky timeout / protocol error flag
//
// state | meaning
// IDLE  | no access; waiting for mem_read or mem_write
// REQ   | pmem_valid asserted with captured fields until pmem_ready
// WAIT  | request accepted; waiting for pmem_ack or timeout
// RESP  | mem_resp pulse; always returns to IDLE
module mem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        pmem_valid,
  input  logic        pmem_ready,
  output logic        pmem_we,
  output logic [31:0] pmem_addr,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_wmask,
  input  logic        pmem_ack,
  input  logic [31:0] pmem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        timeout_hit;

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mem_read || mem_write) state_d = REQ;
      REQ:  if (pmem_ready) state_d = WAIT;
      WAIT: if (pmem_ack || timeout_hit) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_q  <= mem_address;
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
            // simultaneous read+write is resolved as a write and flagged
            we_q    <= mem_write;
            if (mem_read && mem_write) err_q <= 1'b1;
          end
        end
        REQ: if (pmem_ready) cnt_q <= '0;
        WAIT: begin
          // an ack in the terminal cycle still completes normally
          if (pmem_ack) begin
            if (!we_q) rdata_q <= pmem_rdata;
          end else if (timeout_hit) begin
            rdata_q <= 32'hDEAD_BEEF;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pmem_valid = (state_q == REQ);
  assign pmem_we    = we_q;
  assign pmem_addr  = addr_q & 32'hFFFF_FFFC;
  assign pmem_wdata = wdata_q;
  assign pmem_wmask = we_q ? be_q : 4'b0000;
  assign mem_resp   = (state_q == RESP);
  assign mem_rdata  = rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Testbench for mem_bridge (TIMEOUT=4 instance). Scenario tasks drive the CPU
// and physical-memory sides; expected responses go into a scoreboard queue
// when an access is launched and are popped when mem_resp is seen.
module tb_mem_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address, mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        pmem_valid, pmem_ready, pmem_we, pmem_ack, err;
  logic [31:0] pmem_addr, pmem_wdata, pmem_rdata;
  logic [3:0]  pmem_wmask;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_rdata = '0;
  logic        model_err = 1'b0;

  mem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_valid(pmem_valid), .pmem_ready(pmem_ready), .pmem_we(pmem_we),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask),
    .pmem_ack(pmem_ack), .pmem_rdata(pmem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  // One complete access. rdy_dly = REQ cycles before ready; ack_dly = WAIT
  // cycles before the ack cycle, negative for no ack (timeout). drop changes
  // the CPU inputs right after capture.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int rdy_dly, input int ack_dly,
                        input logic [31:0] prd, input bit drop, input string nm);
    bit          tmo = (ack_dly < 0);
    logic [31:0] e_addr = {addr[31:2], 2'b00};
    logic [3:0]  e_mask = wr ? be : 4'b0000;
    int          e_lat = tmo ? 2 + rdy_dly + TO : 3 + rdy_dly + ack_dly;
    int          lat = 0;
    exp_t        e;
    if (rd && wr) model_err = 1'b1;
    if (tmo) begin model_rdata = 32'hDEAD_BEEF; model_err = 1'b1; end
    else if (!wr) model_rdata = prd;
    exp_q.push_back('{rdata: model_rdata, err: model_err});

    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    @(negedge clk); lat++;
    if (drop) begin
      mem_read = 1'b0; mem_write = 1'b0; mem_address = ~addr; mem_wdata = ~wd; mem_byte_enable = ~be;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      n_cmp++; if (pmem_valid !== 1'b1) begin n_bad++; $display("FAIL %s valid[%0d]: got %b want 1", nm, i, pmem_valid); end
      n_cmp++; if (pmem_addr !== e_addr) begin n_bad++; $display("FAIL %s addr[%0d]: got %h want %h", nm, i, pmem_addr, e_addr); end
      n_cmp++; if (pmem_we !== wr) begin n_bad++; $display("FAIL %s we[%0d]: got %b want %b", nm, i, pmem_we, wr); end
      n_cmp++; if (pmem_wmask !== e_mask) begin n_bad++; $display("FAIL %s wmask[%0d]: got %b want %b", nm, i, pmem_wmask, e_mask); end
      if (wr) begin
        n_cmp++; if (pmem_wdata !== wd) begin n_bad++; $display("FAIL %s wdata[%0d]: got %h want %h", nm, i, pmem_wdata, wd); end
      end
      if (i == rdy_dly) pmem_ready = 1'b1;
      @(negedge clk); lat++;
    end
    pmem_ready = 1'b0;
    n_cmp++; if (pmem_valid !== 1'b0) begin n_bad++; $display("FAIL %s valid_in_wait: got %b want 0", nm, pmem_valid); end
    if (!tmo) begin
      repeat (ack_dly) begin @(negedge clk); lat++; end
      pmem_ack = 1'b1; pmem_rdata = prd;
      @(negedge clk); lat++;
      pmem_ack = 1'b0; pmem_rdata = $urandom;
    end
    while (!mem_resp && lat < 300) begin @(negedge clk); lat++; end
    n_cmp++;
    if (mem_resp !== 1'b1) begin n_bad++; $display("FAIL %s resp_timeout: got %b want 1", nm, mem_resp); end
    else if (lat != e_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, lat, e_lat); end
    if (mem_resp === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (mem_rdata !== e.rdata) begin n_bad++; $display("FAIL %s rdata: got %h want %h", nm, mem_rdata, e.rdata); end
      n_cmp++; if (err !== e.err) begin n_bad++; $display("FAIL %s err: got %b want %b", nm, err, e.err); end
    end else exp_q.delete();
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_resp !== 1'b0) begin n_bad++; $display("FAIL %s single_pulse: got %b want 0", nm, mem_resp); end
    n_cmp++; if (pmem_valid !== 1'b0) begin n_bad++; $display("FAIL %s idle_valid: got %b want 0", nm, pmem_valid); end
  endtask

  task automatic check_reset_vals(input string nm);
    n_cmp++; if (mem_resp !== 1'b0) begin n_bad++; $display("FAIL %s mem_resp: got %b want 0", nm, mem_resp); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL %s mem_rdata: got %h want 0", nm, mem_rdata); end
    n_cmp++; if (pmem_valid !== 1'b0) begin n_bad++; $display("FAIL %s pmem_valid: got %b want 0", nm, pmem_valid); end
    n_cmp++; if (pmem_we !== 1'b0) begin n_bad++; $display("FAIL %s pmem_we: got %b want 0", nm, pmem_we); end
    n_cmp++; if (pmem_addr !== 32'h0) begin n_bad++; $display("FAIL %s pmem_addr: got %h want 0", nm, pmem_addr); end
    n_cmp++; if (pmem_wdata !== 32'h0) begin n_bad++; $display("FAIL %s pmem_wdata: got %h want 0", nm, pmem_wdata); end
    n_cmp++; if (pmem_wmask !== 4'h0) begin n_bad++; $display("FAIL %s pmem_wmask: got %b want 0", nm, pmem_wmask); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL %s err: got %b want 0", nm, err); end
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_address = 0;
    mem_wdata = 0; pmem_ready = 0; pmem_ack = 0; pmem_rdata = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");
    model_rdata = '0; model_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_basic;
    access(1, 0, 32'h0000_1006, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 0, "read_basic");
  endtask

  task automatic test_write_delayed;
    access(0, 1, 32'h0000_2000, 32'hCAFE_F00D, 4'b0011, 4, 1, 32'h5555_AAAA, 0, "write_delayed");
  endtask

  task automatic test_input_drop;
    access(1, 0, 32'h0000_3008, 32'h0, 4'h0, 2, 2, 32'hA5A5_0F0F, 1, "input_drop");
    access(0, 1, 32'h0000_300F, 32'h1357_9BDF, 4'b1001, 1, 0, 32'h0, 1, "input_drop_wr");
  endtask

  task automatic test_ack_on_last;
    access(1, 0, 32'h0000_4000, 32'h0, 4'h0, 0, TO - 1, 32'h0BAD_CAFE, 0, "ack_on_last");
  endtask

  task automatic test_timeout;
    access(1, 0, 32'h0000_5004, 32'h0, 4'h0, 1, -1, 32'h0, 0, "timeout");
    access(1, 0, 32'h0000_5008, 32'h0, 4'h0, 0, 1, 32'h7777_1111, 0, "err_sticky");
  endtask

  task automatic test_back_to_back;
    int   acc_cnt = 0, resp_cnt = 0, last_resp = -10;
    bit   outstanding = 0, ack_pend = 0;
    logic [31:0] val = '0;
    exp_t e;
    mem_read = 1'b1; mem_address = 32'h0000_6000; pmem_ready = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 24) mem_read = 1'b0;
      pmem_ack = 1'b0;
      if (ack_pend) begin pmem_ack = 1'b1; pmem_rdata = val; ack_pend = 0; end
      if (mem_resp === 1'b1) begin
        resp_cnt++; outstanding = 0; last_resp = c;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++; if (mem_rdata !== e.rdata) begin n_bad++; $display("FAIL b2b rdata: got %h want %h", mem_rdata, e.rdata); end
        end else begin
          n_cmp++; n_bad++; $display("FAIL b2b unexpected_resp: got 1 want 0");
        end
      end
      if (pmem_valid === 1'b1 && pmem_ready === 1'b1) begin
        acc_cnt++;
        n_cmp++; if (outstanding || (c - last_resp) < 2) begin n_bad++; $display("FAIL b2b overlap: got cycle %0d want >= %0d", c, last_resp + 2); end
        outstanding = 1; ack_pend = 1; val = $urandom;
        model_rdata = val;
        exp_q.push_back('{rdata: val, err: model_err});
      end
    end
    pmem_ack = 1'b0; pmem_ready = 1'b0;
    n_cmp++; if (resp_cnt != 6) begin n_bad++; $display("FAIL b2b resp_count: got %0d want 6", resp_cnt); end
    n_cmp++; if (acc_cnt != resp_cnt) begin n_bad++; $display("FAIL b2b accept_count: got %0d want %0d", acc_cnt, resp_cnt); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_access;
    int seen = 0;
    mem_read = 1'b1; mem_address = 32'h0000_7010;
    @(negedge clk);
    pmem_ready = 1'b1;
    @(negedge clk);
    pmem_ready = 1'b0;
    n_cmp++; if (pmem_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid pre_wait_valid: got %b want 0", pmem_valid); end
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst_mid");
    model_rdata = '0; model_err = 1'b0;
    pmem_ack = 1'b1; pmem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    pmem_ack = 1'b0;
    repeat (4) begin
      if (mem_resp === 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_mid late_ack_resp: got %0d want 0", seen); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mid late_ack_rdata: got %h want 0", mem_rdata); end
    access(1, 0, 32'h0000_7020, 32'h0, 4'h0, 0, 0, 32'h2468_ACE0, 0, "after_rst");
  endtask

  task automatic test_rw_both;
    access(1, 1, 32'h0000_8003, 32'h1122_3344, 4'b1100, 0, 0, 32'h9999_9999, 0, "rw_both");
    access(1, 0, 32'h0000_8008, 32'h0, 4'h0, 0, 0, 32'h0F0F_F0F0, 0, "rw_err_sticky");
  endtask

  initial begin
    test_reset;
    test_read_basic;
    test_write_delayed;
    test_input_drop;
    test_ack_on_last;
    test_timeout;
    test_back_to_back;
    test_reset_mid_access;
    test_rw_both;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max WAIT cycles before an access is aborted (range 2..255).
REQ-002 SHALL have clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have mem_read  in  1  CPU read request, level, held until mem_resp.
REQ-005 SHALL have mem_write  in  1  CPU write request, level, held until mem_resp.
REQ-006 SHALL have mem_byte_enable  in  4  CPU write byte mask.
REQ-007 SHALL have mem_address  in  32  CPU byte address.
REQ-008 SHALL have mem_wdata  in  32  CPU write data.
REQ-009 SHALL have mem_resp  out  1  one-cycle completion pulse to CPU.
REQ-010 SHALL have mem_rdata  out  32  read data, valid while mem_resp=1.
REQ-011 SHALL have pmem_valid  out  1  request valid to physical memory.
REQ-012 SHALL have pmem_ready  in  1  physical memory accepts request when pmem_valid&pmem_ready.
REQ-013 SHALL have pmem_we  out  1  1=write, 0=read.
REQ-014 SHALL have pmem_addr  out  32  word address, bits [1:0] forced 0.
REQ-015 SHALL have pmem_wdata  out  32  write data; pmem_wmask  out  4  byte mask (4'b0000 on reads).
REQ-016 SHALL have pmem_ack  in  1  completion pulse; pmem_rdata  in  32  valid with pmem_ack on reads.
REQ-017 SHALL have err  out  1  sticky: a timeout or protocol error has occurred.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-019 IDLE: on mem_read|mem_write SHALL capture address, wdata, byte_enable, and direction into internal registers, then go to REQ.
REQ-020 mem_read&mem_write together SHALL be treated as a write and SHALL set err.
REQ-021 REQ: pmem_valid=1 with captured fields; on pmem_ready SHALL go to WAIT, else stay in REQ (no timeout in REQ).
REQ-022 pmem_valid/pmem_we/pmem_addr/pmem_wdata/pmem_wmask SHALL be stable from REQ entry until acceptance; pmem_valid=0 in all other states.
REQ-023 WAIT: 8-bit counter SHALL clear on WAIT entry and increment each WAIT cycle without pmem_ack.
REQ-024 WAIT with pmem_ack SHALL register pmem_rdata (reads) into mem_rdata and go to RESP.
REQ-025 WAIT with counter==TIMEOUT-1 and no pmem_ack SHALL set mem_rdata=32'hDEADBEEF, set err, go to RESP; pmem_ack in the same cycle wins (normal completion, err unchanged).
REQ-026 RESP: mem_resp=1 for exactly one cycle, then SHALL go unconditionally to IDLE (stale held request level is not re-sampled in RESP).
REQ-027 For writes, mem_rdata SHALL hold its previous value.
REQ-028 Minimum latency: request seen in IDLE cycle N, pmem_valid cycle N+1, ready at N+1 and ack at N+2 -> mem_resp at N+3.
REQ-029 CPU inputs changing or dropping after capture SHALL NOT affect the in-flight access; mem_resp SHALL still pulse.
REQ-030 pmem_ack received in IDLE, REQ or RESP SHALL be ignored.
REQ-031 Only one access outstanding at any time.

Reset
REQ-032 On rst: state=IDLE, mem_resp=0, mem_rdata=0, pmem_valid=0, pmem_we=0, pmem_addr=0, pmem_wdata=0, pmem_wmask=0, counter=0, err=0.
REQ-033 rst mid-access SHALL abandon the access with no mem_resp; pmem_valid=0 in the cycle after rst; a late pmem_ack SHALL be ignored.
REQ-034 err SHALL clear only on rst.

Verification
REQ-035 Read 0x0000_1006, pmem_ready=1 immediately, ack 1 cycle later with rdata 0x12345678 -> pmem_addr=0x0000_1004, pmem_wmask=0, mem_resp 3 cycles after request with mem_rdata=0x12345678, single pulse.
REQ-036 Write 0x0000_2000, data 0xCAFEF00D, byte_enable 4'b0011, pmem_ready delayed 4 cycles -> pmem_valid held 5 cycles, fields stable, pmem_we=1, wmask=4'b0011, one mem_resp after ack.
REQ-037 TIMEOUT=4, read accepted, no ack -> mem_resp after 4 WAIT cycles, mem_rdata=0xDEADBEEF, err=1 and stays 1; ack on 4th WAIT cycle instead -> normal data, err=0.
REQ-038 mem_read held high across RESP and 2 further cycles (CPU lag) -> exactly one new access per IDLE sample, never two pmem_valid acceptances for one mem_resp without an IDLE cycle between.
REQ-039 rst asserted while in WAIT, ack arrives after rst -> no mem_resp, all outputs at reset values, next request processed normally.
REQ-040 mem_read=mem_write=1 -> write issued (pmem_we=1), err=1.
